// File: rtl/smem_bank_pipe_if.sv
// rtl/smem_bank_pipe_if.sv - request/response channel bundle between crossbar and shared-memory bank
interface smem_bank_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // Crossbar side issues requests and consumes responses
    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // Bank side accepts requests and produces responses
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/smem_bank_pipe.sv
// rtl/smem_bank_pipe.sv - shared-memory bank with clear-after-reset and optional atomic add (SMEM_ATOMIC_EN)
module smem_bank_pipe #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int BANK_ID = 0
) (
    input  logic             clock,
    input  logic             reset,
    smem_bank_pipe_if.slave  bus,
    output logic             busy,
    output logic [3:0]       bank_id
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CLR_STEP = (ADDR_W+1)'(1);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
`ifdef SMEM_ATOMIC_EN
    localparam logic [1:0] OP_ADD   = 2'b10;
`endif

`ifdef SMEM_ATOMIC_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RMW} state_t;
`else
    typedef enum logic [1:0] {ST_INIT, ST_IDLE} state_t;
`endif

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   clr_cnt;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_err_q;
    logic              req_ready_c;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
`ifdef SMEM_ATOMIC_EN
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_old;
    logic [DATA_W-1:0] rmw_opnd;
`endif

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = (state == ST_INIT);
    assign bank_id        = 4'(BANK_ID);

    // State register; reset restarts the clear sweep
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_INIT;
        else        state <= next_state;
    end

    // Next state, request acceptance and the single memory write port
    always_comb begin
        next_state  = state;
        req_ready_c = 1'b0;
        accept      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        case (state)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt[ADDR_W-1:0];
                if (clr_cnt == CLR_LAST) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                // A pending response may be replaced on the edge it is consumed
                req_ready_c = !resp_valid_q || bus.resp_ready;
                accept      = bus.req_valid && req_ready_c;
                if (accept && bus.req_op == OP_WRITE) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.req_addr;
                    mem_wdata = bus.req_wdata;
                end
`ifdef SMEM_ATOMIC_EN
                if (accept && bus.req_op == OP_ADD) next_state = ST_RMW;
`endif
            end
`ifdef SMEM_ATOMIC_EN
            ST_RMW: begin
                mem_we     = 1'b1;
                mem_waddr  = rmw_addr;
                mem_wdata  = rmw_old + rmw_opnd;
                next_state = ST_IDLE;
            end
`endif
            default: next_state = ST_INIT;
        endcase
    end

    // Storage array, no reset: contents are cleared by the INIT sweep
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Clear counter, response buffer and atomic operand capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_cnt      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
`ifdef SMEM_ATOMIC_EN
            rmw_addr     <= '0;
            rmw_old      <= '0;
            rmw_opnd     <= '0;
`endif
        end else begin
            if (state == ST_INIT) clr_cnt <= clr_cnt + CLR_STEP;
            if (resp_valid_q && bus.resp_ready) resp_valid_q <= 1'b0;
            if (accept) begin
                case (bus.req_op)
                    OP_READ: begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= mem[bus.req_addr];
                        resp_err_q   <= 1'b0;
                    end
                    OP_WRITE: begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= bus.req_wdata;
                        resp_err_q   <= 1'b0;
                    end
`ifdef SMEM_ATOMIC_EN
                    OP_ADD: begin
                        rmw_addr <= bus.req_addr;
                        rmw_old  <= mem[bus.req_addr];
                        rmw_opnd <= bus.req_wdata;
                    end
`endif
                    default: begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                    end
                endcase
            end
`ifdef SMEM_ATOMIC_EN
            if (state == ST_RMW) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= rmw_old;
                resp_err_q   <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_smem_bank_pipe.sv
// tb/tb_smem_bank_pipe.sv - scoreboard bench for smem_bank_pipe
module tb_smem_bank_pipe;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic [3:0] bank_id;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    smem_bank_pipe_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    smem_bank_pipe #(.DATA_W(8), .ADDR_W(8), .BANK_ID(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .bank_id (bank_id)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pop the expected response whenever one is handed over
    always @(negedge clock) begin
        if (reset && bus.resp_valid && bus.resp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got data %0h err %0b want no response", bus.resp_data, bus.resp_err);
            end else begin
                mon_e = q.pop_front();
                chk("resp_data", bus.resp_data, mon_e.d);
                chk("resp_err", bus.resp_err, mon_e.e);
            end
        end
    end

    // Issue one request (called at posedge+1); returns the cycle count after the accept edge
    task automatic send(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] ed, input logic ee, input bit push, output int acc_cyc);
        bit got;
        bit ok;
        ok = 0;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            #1;
            got = bus.req_ready;
            @(posedge clock);
            #1;
            if (got) begin
                ok = 1;
                break;
            end
        end
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: op %0d addr %0h never accepted, want accepted", op, addr);
        end else if (push) begin
            q.push_back('{ed, ee});
        end
    endtask

    // Clear sweep: count busy cycles while a request is held pending
    task automatic init_phase();
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 8'h00;
        bus.req_valid = 1'b1;
        while (n < 1000) begin
            @(negedge clock);
            if (!busy) break;
            if (bus.req_ready) rdy_seen = 1;
            n++;
        end
        bus.req_valid = 1'b0;
        chk("busy_cycles", n, 256);
        chk("ready_in_init", rdy_seen, 0);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_resp_data"}, bus.resp_data, 0);
        chk({tag, "_resp_err"}, bus.resp_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c1, c2, c3, c0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_addr   = 8'h00;
        bus.req_wdata  = 8'h00;
        bus.resp_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("por");
        chk("bank_id", bank_id, 4'd3);

        reset = 1'b1;
        init_phase();

        for (int a = 0; a < 256; a++) send(2'b00, 8'(a), 8'h00, 8'h00, 1'b0, 1, c);
        drain();

        send(2'b01, 8'h10, 8'h5A, 8'h5A, 1'b0, 1, c1);
        send(2'b00, 8'h10, 8'h00, 8'h5A, 1'b0, 1, c2);
        send(2'b00, 8'h10, 8'h00, 8'h5A, 1'b0, 1, c3);
        chk("b2b_gap1", c2 - c1, 1);
        chk("b2b_gap2", c3 - c2, 1);
        drain();

        bus.resp_ready = 1'b0;
        send(2'b00, 8'h10, 8'h00, 8'h5A, 1'b0, 1, c);
        bus.req_op    = 2'b00;
        bus.req_addr  = 8'h11;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_data", bus.resp_data, 8'h5A);
            chk("hold_err", bus.resp_err, 0);
            chk("hold_ready", bus.req_ready, 0);
            @(posedge clock);
            #1;
        end
        bus.resp_ready = 1'b1;
        c0 = cyc;
        send(2'b00, 8'h11, 8'h00, 8'h00, 1'b0, 1, c);
        chk("same_edge_accept", c, c0 + 1);
        drain();

        send(2'b11, 8'h20, 8'hAB, 8'h00, 1'b1, 1, c);
        send(2'b00, 8'h20, 8'h00, 8'h00, 1'b0, 1, c);

        send(2'b01, 8'h30, 8'hF0, 8'hF0, 1'b0, 1, c);
`ifdef SMEM_ATOMIC_EN
        send(2'b10, 8'h30, 8'h20, 8'hF0, 1'b0, 1, c);
        send(2'b00, 8'h30, 8'h00, 8'h10, 1'b0, 1, c);
`else
        send(2'b10, 8'h30, 8'h20, 8'h00, 1'b1, 1, c);
        send(2'b00, 8'h30, 8'h00, 8'hF0, 1'b0, 1, c);
`endif
        drain();

`ifdef SMEM_ATOMIC_EN
        send(2'b10, 8'h30, 8'h01, 8'h00, 1'b0, 0, c);
`else
        send(2'b01, 8'h30, 8'h77, 8'h00, 1'b0, 0, c);
`endif
        reset = 1'b0;
        q.delete();
        #1;
        chk_reset_outputs("mid_op");
        @(posedge clock);
        #1;
        reset = 1'b1;
        init_phase();
        send(2'b00, 8'h30, 8'h00, 8'h00, 1'b0, 1, c);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
